// File: rtl/pq_pkg.sv
// Shared types for the priority-queue study: key/value widths, cell layout
// and the per-cell operation encoding used by the shift-register queue.
package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef struct packed {
        logic valid;
        kv_t  kv;
    } pq_cell_t;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        SHIFT_IN  = 2'd1,
        LOAD      = 2'd2,
        SHIFT_OUT = 2'd3
    } cell_op_e;
endpackage

// File: rtl/sr_pq_cell.sv
// One storage cell of the shift-register priority queue. Chooses its own
// hold/shift/load operation from its neighbours and registers its entry.
module sr_pq_cell
    import pq_pkg::*;
#(
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH,
    parameter bit IS_HEAD   = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           replace_i,
    input  logic                           deq_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi_i,
    input  logic                           prev_valid_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] prev_kv_i,
    input  logic                           prev_le_i,
    input  logic                           next_valid_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] next_kv_i,
    input  logic                           next_le_i,
    output logic                           valid_o,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_o,
    output logic                           le_o
);
    localparam int KVW = KEY_WIDTH + VAL_WIDTH;

    logic           valid_q, valid_d;
    logic [KVW-1:0] kv_q, kv_d;
    cell_op_e       op;

    // le_o: this cell keeps priority over the incoming entry (ties stay ahead)
    assign le_o    = valid_q && (kv_q[KVW-1:VAL_WIDTH] <= kvi_i[KVW-1:VAL_WIDTH]);
    assign valid_o = valid_q;
    assign kv_o    = kv_q;

    // Replace+deq is an insert into the list that starts at cell 1, so the
    // roles of "own" and "next" cell take the place of "prev" and "own".
    always_comb begin
        op = HOLD;
        if (replace_i && deq_i) begin
            if (next_le_i)              op = SHIFT_OUT;
            else if (IS_HEAD || le_o)   op = LOAD;
            else                        op = HOLD;
        end else if (replace_i) begin
            if (le_o)                   op = HOLD;
            else if (prev_le_i)         op = LOAD;
            else                        op = SHIFT_IN;
        end else if (deq_i) begin
            op = SHIFT_OUT;
        end
    end

    always_comb begin
        valid_d = valid_q;
        kv_d    = kv_q;
        case (op)
            SHIFT_IN: begin
                valid_d = prev_valid_i;
                kv_d    = prev_kv_i;
            end
            LOAD: begin
                valid_d = 1'b1;
                kv_d    = kvi_i;
            end
            SHIFT_OUT: begin
                valid_d = next_valid_i;
                kv_d    = next_kv_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            kv_q    <= '0;
        end else begin
            valid_q <= valid_d;
            kv_q    <= kv_d;
        end
    end
endmodule

// File: rtl/sr_pq_s.sv
// Shift-register priority queue: PQ_SIZE cells kept sorted by ascending key
// with the head entry in cell 0, plus occupancy count and event flags.
module sr_pq_s
    import pq_pkg::*;
#(
    parameter int PQ_SIZE   = 8,
    parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           replace,
    input  logic                           deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kvi,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] kvo,
    output logic                           ovalid,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(PQ_SIZE+1)-1:0]   count,
    output logic                           drop,
    output logic                           err
);
    localparam int KVW = KEY_WIDTH + VAL_WIDTH;
    localparam int CW  = $clog2(PQ_SIZE + 1);

    logic           c_valid [PQ_SIZE];
    logic [KVW-1:0] c_kv    [PQ_SIZE];
    logic           c_le    [PQ_SIZE];

    logic [CW-1:0]  count_q, count_d;
    logic           drop_q, drop_d;
    logic           err_q, err_d;
    logic           deq_eff;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(PQ_SIZE));
    // An empty-queue deq only raises err; it must not disturb the cells
    assign deq_eff = deq && !empty;

    for (genvar i = 0; i < PQ_SIZE; i++) begin : g_cell
        logic           pv, pl, nv, nl;
        logic [KVW-1:0] pk, nk;

        if (i == 0) begin : g_head
            assign pv = 1'b0;
            assign pk = '0;
            assign pl = 1'b1;
        end else begin : g_body
            assign pv = c_valid[i-1];
            assign pk = c_kv[i-1];
            assign pl = c_le[i-1];
        end

        if (i == PQ_SIZE - 1) begin : g_tail
            assign nv = 1'b0;
            assign nk = '0;
            assign nl = 1'b0;
        end else begin : g_inner
            assign nv = c_valid[i+1];
            assign nk = c_kv[i+1];
            assign nl = c_le[i+1];
        end

        sr_pq_cell #(
            .KEY_WIDTH (KEY_WIDTH),
            .VAL_WIDTH (VAL_WIDTH),
            .IS_HEAD   (i == 0)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .replace_i    (replace),
            .deq_i        (deq_eff),
            .kvi_i        (kvi),
            .prev_valid_i (pv),
            .prev_kv_i    (pk),
            .prev_le_i    (pl),
            .next_valid_i (nv),
            .next_kv_i    (nk),
            .next_le_i    (nl),
            .valid_o      (c_valid[i]),
            .kv_o         (c_kv[i]),
            .le_o         (c_le[i])
        );
    end

    // Full-queue insert either holds everything or evicts the tail; count stays
    always_comb begin
        count_d = count_q;
        drop_d  = 1'b0;
        err_d   = deq && empty;
        if (replace && !deq_eff) begin
            if (full) drop_d  = 1'b1;
            else      count_d = count_q + CW'(1);
        end else if (!replace && deq_eff) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    assign kvo    = c_kv[0];
    assign ovalid = c_valid[0];
    assign count  = count_q;
    assign drop   = drop_q;
    assign err    = err_q;
endmodule

// File: tb/tb_sr_pq_s.sv
// Directed scoreboard bench for sr_pq_s: an 8-entry and a 4-entry instance.
module tb_sr_pq_s;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rep8 = 1'b0, deq8 = 1'b0, rep4 = 1'b0, deq4 = 1'b0;
    logic [15:0] kvi8 = '0, kvi4 = '0;
    logic [15:0] kvo8, kvo4;
    logic        ov8, em8, fu8, dr8, er8;
    logic        ov4, em4, fu4, dr4, er4;
    logic [3:0]  cnt8;
    logic [2:0]  cnt4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        bit          sel;      // 0: 8-entry DUT, 1: 4-entry DUT
        logic [15:0] kvo;
        bit          kvo_chk;
        logic [3:0]  cnt;
        bit          err;
        bit          drop;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    sr_pq_s dut8 (
        .clk(clk), .rst_n(rst_n), .replace(rep8), .deq(deq8), .kvi(kvi8),
        .kvo(kvo8), .ovalid(ov8), .empty(em8), .full(fu8), .count(cnt8),
        .drop(dr8), .err(er8)
    );

    sr_pq_s #(.PQ_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .replace(rep4), .deq(deq4), .kvi(kvi4),
        .kvo(kvo4), .ovalid(ov4), .empty(em4), .full(fu4), .count(cnt4),
        .drop(dr4), .err(er4)
    );

    task automatic compare(input exp_t e);
        logic [15:0] a_kvo;
        logic [3:0]  a_cnt;
        logic        a_ov, a_em, a_fu, a_dr, a_er;
        bit          e_ov, e_em, e_fu, ok;
        if (e.sel) begin
            a_kvo = kvo4; a_cnt = {1'b0, cnt4}; a_ov = ov4; a_em = em4;
            a_fu = fu4; a_dr = dr4; a_er = er4;
        end else begin
            a_kvo = kvo8; a_cnt = cnt8; a_ov = ov8; a_em = em8;
            a_fu = fu8; a_dr = dr8; a_er = er8;
        end
        e_ov = (e.cnt != 4'd0);
        e_em = (e.cnt == 4'd0);
        e_fu = (e.cnt == (e.sel ? 4'd4 : 4'd8));
        ok = (a_cnt === e.cnt) && (a_ov === e_ov) && (a_em === e_em) &&
             (a_fu === e_fu) && (a_dr === e.drop) && (a_er === e.err) &&
             (!e.kvo_chk || (a_kvo === e.kvo));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got kvo=%h ovalid=%b count=%0d empty=%b full=%b drop=%b err=%b; want kvo=%h(chk=%0d) ovalid=%b count=%0d empty=%b full=%b drop=%b err=%b",
                     e.name, a_kvo, a_ov, a_cnt, a_em, a_fu, a_dr, a_er,
                     e.kvo, e.kvo_chk, e_ov, e.cnt, e_em, e_fu, e.drop, e.err);
        end
    endtask

    // Monitor: each issued operation is checked just after the edge that applies it
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) compare(exp_q.pop_front());
    end

    task automatic step(input bit sel, input bit r, input bit d, input logic [15:0] k,
                        input string nm, input logic [15:0] ekvo, input logic [3:0] ecnt,
                        input bit eerr, input bit edrop);
        exp_t e;
        @(negedge clk);
        rep8 = 1'b0; deq8 = 1'b0; kvi8 = '0;
        rep4 = 1'b0; deq4 = 1'b0; kvi4 = '0;
        if (sel) begin rep4 = r; deq4 = d; kvi4 = k; end
        else     begin rep8 = r; deq8 = d; kvi8 = k; end
        e.name = nm; e.sel = sel; e.kvo = ekvo; e.kvo_chk = (ecnt != 4'd0);
        e.cnt = ecnt; e.err = eerr; e.drop = edrop;
        exp_q.push_back(e);
    endtask

    function automatic exp_t direct(input string nm, input bit sel);
        exp_t e;
        e.name = nm; e.sel = sel; e.kvo = 16'h0000; e.kvo_chk = 1'b1;
        e.cnt = 4'd0; e.err = 1'b0; e.drop = 1'b0;
        return e;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        compare(direct("reset8", 1'b0));
        compare(direct("reset4", 1'b1));
        rst_n = 1'b1;

        // sel r d kvi          name        kvo      cnt err drop
        step(0, 1, 0, 16'h080E, "ins8",     16'h080E, 1, 0, 0);
        step(0, 1, 0, 16'h0B0B, "ins11",    16'h080E, 2, 0, 0);
        step(0, 1, 0, 16'h0909, "ins9",     16'h080E, 3, 0, 0);
        step(0, 1, 0, 16'h0A0A, "ins10",    16'h080E, 4, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_a",    16'h0909, 3, 0, 0);
        step(0, 1, 0, 16'h0101, "ins1",     16'h0101, 4, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_b",    16'h0909, 3, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_c",    16'h0A0A, 2, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_d",    16'h0B0B, 1, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_last", 16'h0000, 0, 0, 0);
        step(0, 0, 1, 16'h0000, "deq_empty",16'h0000, 0, 1, 0);
        step(0, 0, 0, 16'h0000, "err_clr",  16'h0000, 0, 0, 0);
        // ties keep insertion order
        step(0, 1, 0, 16'h0401, "tie1",     16'h0401, 1, 0, 0);
        step(0, 1, 0, 16'h0402, "tie2",     16'h0401, 2, 0, 0);
        step(0, 1, 0, 16'h0403, "tie3",     16'h0401, 3, 0, 0);
        step(0, 0, 1, 16'h0000, "tie_deq1", 16'h0402, 2, 0, 0);
        step(0, 0, 1, 16'h0000, "tie_deq2", 16'h0403, 1, 0, 0);
        step(0, 0, 1, 16'h0000, "tie_deq3", 16'h0000, 0, 0, 0);
        // simultaneous replace + deq
        step(0, 1, 0, 16'h0202, "s_ins2",   16'h0202, 1, 0, 0);
        step(0, 1, 0, 16'h0505, "s_ins5",   16'h0202, 2, 0, 0);
        step(0, 1, 0, 16'h0909, "s_ins9",   16'h0202, 3, 0, 0);
        step(0, 1, 1, 16'h0606, "s_repdeq", 16'h0505, 3, 0, 0);
        step(0, 0, 1, 16'h0000, "s_deq6",   16'h0606, 2, 0, 0);
        step(0, 0, 1, 16'h0000, "s_deq9",   16'h0909, 1, 0, 0);
        step(0, 0, 1, 16'h0000, "s_deqe",   16'h0000, 0, 0, 0);
        step(0, 1, 1, 16'h0606, "s_rd_empty",16'h0606, 1, 1, 0);
        step(0, 0, 0, 16'h0000, "s_idle",   16'h0606, 1, 0, 0);
        // 4-entry instance: overflow handling
        step(1, 1, 0, 16'h0505, "f_ins5",   16'h0505, 1, 0, 0);
        step(1, 1, 0, 16'h0303, "f_ins3",   16'h0303, 2, 0, 0);
        step(1, 1, 0, 16'h0707, "f_ins7",   16'h0303, 3, 0, 0);
        step(1, 1, 0, 16'h0101, "f_ins1",   16'h0101, 4, 0, 0);
        step(1, 1, 0, 16'h0909, "f_drop9",  16'h0101, 4, 0, 1);
        step(1, 1, 0, 16'h0202, "f_evict7", 16'h0101, 4, 0, 1);
        step(1, 0, 0, 16'h0000, "f_idle",   16'h0101, 4, 0, 0);
        step(1, 0, 1, 16'h0000, "f_deq1",   16'h0202, 3, 0, 0);
        step(1, 0, 1, 16'h0000, "f_deq2",   16'h0303, 2, 0, 0);
        step(1, 0, 1, 16'h0000, "f_deq3",   16'h0505, 1, 0, 0);
        step(1, 0, 1, 16'h0000, "f_deq5",   16'h0000, 0, 0, 0);
        step(1, 1, 0, 16'h0101, "g_ins1",   16'h0101, 1, 0, 0);
        step(1, 1, 0, 16'h0202, "g_ins2",   16'h0101, 2, 0, 0);
        step(1, 1, 0, 16'h0303, "g_ins3",   16'h0101, 3, 0, 0);
        step(1, 1, 0, 16'h0404, "g_ins4",   16'h0101, 4, 0, 0);
        step(1, 1, 1, 16'h0505, "g_rd_full",16'h0202, 4, 0, 0);
        // build count=3 on the 8-entry DUT, then reset between edges
        step(0, 1, 0, 16'h0303, "r_ins3",   16'h0303, 2, 0, 0);
        step(0, 1, 0, 16'h0707, "r_ins7",   16'h0303, 3, 0, 0);
        @(posedge clk);
        #3;
        rep8 = 1'b0; deq8 = 1'b0; kvi8 = '0;
        rep4 = 1'b0; deq4 = 1'b0; kvi4 = '0;
        rst_n = 1'b0;
        #1;
        compare(direct("async_rst8", 1'b0));
        compare(direct("async_rst4", 1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 16'h0000, "post_rst", 16'h0000, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
